// File: rtl/spi_master_driver.sv
// Mode-0 SPI master: one frame per accepted send_start, optional ss hold between frames.
// Every output comes straight from a flop; the comb block computes all next values.
//
// state   | meaning
// S_IDLE  | ss deasserted, ready for a new frame
// S_SETUP | ss asserted, sclk low for HALF cycles before the first rising edge
// S_HIGH  | sclk high for HALF cycles, miso sampled on the last cycle
// S_LOW   | sclk low for HALF cycles, next mosi bit already on the line
// S_HOLD  | ss held asserted between back-to-back frames, ready for a new frame
// S_GAP   | ss deasserted for HALF cycles (minimum deselect time)
module spi_master_driver #(
  parameter int SYS_FREQ_HZ       = 48_000_000,
  parameter int SPI_FREQ_HZ       = 1_000_000,
  parameter int NUM_DATA_BITS     = 8,
  parameter bit SPI_SS_ACTIVE_LOW = 1'b1,
  parameter bit SPI_LSB_FIRST     = 1'b0
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     send_start,
  input  logic                     keep_alive,
  input  logic [NUM_DATA_BITS-1:0] send_data,
  input  logic                     miso_in,
  output logic                     send_ready,
  output logic                     send_done,
  output logic [NUM_DATA_BITS-1:0] recv_data,
  output logic                     ss_out,
  output logic                     sclk_out,
  output logic                     mosi_out
);

  localparam int HALF_RAW = SYS_FREQ_HZ / (2 * SPI_FREQ_HZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int HALF_W   = $clog2(HALF + 1);
  localparam int BIT_W    = $clog2(NUM_DATA_BITS + 1);

  localparam logic                     SS_ON     = SPI_SS_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic [HALF_W-1:0]        HALF_LAST = HALF_W'(HALF - 1);
  localparam logic [HALF_W-1:0]        HALF_ONE  = HALF_W'(1);
  localparam logic [BIT_W-1:0]         BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]         BITS_ALL  = BIT_W'(NUM_DATA_BITS);
  localparam logic [NUM_DATA_BITS-1:0] DATA_ONE  = NUM_DATA_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  state_t                   r_state;
  logic [HALF_W-1:0]        r_half_cnt;
  logic [BIT_W-1:0]         r_bit_cnt;
  logic [NUM_DATA_BITS-1:0] r_tx_shift;
  logic [NUM_DATA_BITS-1:0] r_rx_shift;
  logic [NUM_DATA_BITS-1:0] r_recv_data;
  logic                     r_ss;
  logic                     r_sclk;
  logic                     r_mosi;
  logic                     r_ready;
  logic                     r_done;

  state_t                   w_state_nxt;
  logic [HALF_W-1:0]        w_half_nxt;
  logic [BIT_W-1:0]         w_bit_nxt;
  logic [NUM_DATA_BITS-1:0] w_tx_nxt;
  logic [NUM_DATA_BITS-1:0] w_rx_nxt;
  logic [NUM_DATA_BITS-1:0] w_recv_nxt;
  logic                     w_ss_nxt;
  logic                     w_sclk_nxt;
  logic                     w_mosi_nxt;
  logic                     w_ready_nxt;
  logic                     w_done_nxt;
  logic                     w_half_last;
  logic [NUM_DATA_BITS-1:0] w_tx_shifted;

  // The bit that goes on mosi next is always at the "leading" end of the tx register.
  function automatic logic f_out_bit(input logic [NUM_DATA_BITS-1:0] d);
    return SPI_LSB_FIRST ? d[0] : d[NUM_DATA_BITS-1];
  endfunction

  function automatic logic [NUM_DATA_BITS-1:0] f_tx_shift(input logic [NUM_DATA_BITS-1:0] d);
    return SPI_LSB_FIRST ? (d >> 1) : (d << 1);
  endfunction

  // First sampled bit ends up at the same end it was transmitted from.
  function automatic logic [NUM_DATA_BITS-1:0] f_rx_shift(input logic [NUM_DATA_BITS-1:0] d,
                                                          input logic                     b);
    if (SPI_LSB_FIRST)
      return (d >> 1) | (b ? (DATA_ONE << (NUM_DATA_BITS - 1)) : '0);
    else
      return (d << 1) | (b ? DATA_ONE : '0);
  endfunction

  assign w_half_last  = (r_half_cnt == HALF_LAST);
  assign w_tx_shifted = f_tx_shift(r_tx_shift);

  always_comb begin
    w_state_nxt = r_state;
    w_half_nxt  = r_half_cnt + HALF_ONE;
    w_bit_nxt   = r_bit_cnt;
    w_tx_nxt    = r_tx_shift;
    w_rx_nxt    = r_rx_shift;
    w_recv_nxt  = r_recv_data;
    w_ss_nxt    = r_ss;
    w_sclk_nxt  = r_sclk;
    w_mosi_nxt  = r_mosi;
    w_ready_nxt = r_ready;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE, S_HOLD: begin
        w_half_nxt = '0;
        if (send_start) begin
          w_state_nxt = S_SETUP;
          w_tx_nxt    = send_data;
          w_rx_nxt    = '0;
          w_bit_nxt   = '0;
          w_mosi_nxt  = f_out_bit(send_data);
          w_ss_nxt    = SS_ON;
          w_ready_nxt = 1'b0;
        end else if (r_state == S_HOLD && !keep_alive) begin
          w_state_nxt = S_GAP;
          w_ss_nxt    = ~SS_ON;
          w_ready_nxt = 1'b0;
        end
      end

      S_SETUP: begin
        if (w_half_last) begin
          w_state_nxt = S_HIGH;
          w_half_nxt  = '0;
          w_sclk_nxt  = 1'b1;
        end
      end

      S_HIGH: begin
        if (w_half_last) begin
          w_state_nxt = S_LOW;
          w_half_nxt  = '0;
          w_sclk_nxt  = 1'b0;
          w_rx_nxt    = f_rx_shift(r_rx_shift, miso_in);
          w_bit_nxt   = r_bit_cnt + BIT_ONE;
          // Falling edge: present the next bit so it is stable before the next rise.
          if (r_bit_cnt + BIT_ONE != BITS_ALL) begin
            w_tx_nxt   = w_tx_shifted;
            w_mosi_nxt = f_out_bit(w_tx_shifted);
          end
        end
      end

      S_LOW: begin
        if (w_half_last) begin
          w_half_nxt = '0;
          if (r_bit_cnt != BITS_ALL) begin
            w_state_nxt = S_HIGH;
            w_sclk_nxt  = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
            w_recv_nxt = r_rx_shift;
            if (keep_alive) begin
              w_state_nxt = S_HOLD;
              w_ready_nxt = 1'b1;
            end else begin
              w_state_nxt = S_GAP;
              w_ss_nxt    = ~SS_ON;
            end
          end
        end
      end

      S_GAP: begin
        if (w_half_last) begin
          w_state_nxt = S_IDLE;
          w_half_nxt  = '0;
          w_ready_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_half_nxt  = '0;
        w_ss_nxt    = ~SS_ON;
        w_sclk_nxt  = 1'b0;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_half_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_recv_data <= '0;
      r_ss        <= ~SS_ON;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_half_cnt  <= w_half_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_tx_shift  <= w_tx_nxt;
      r_rx_shift  <= w_rx_nxt;
      r_recv_data <= w_recv_nxt;
      r_ss        <= w_ss_nxt;
      r_sclk      <= w_sclk_nxt;
      r_mosi      <= w_mosi_nxt;
      r_ready     <= w_ready_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign send_ready = r_ready;
  assign send_done  = r_done;
  assign recv_data  = r_recv_data;
  assign ss_out     = r_ss;
  assign sclk_out   = r_sclk;
  assign mosi_out   = r_mosi;

endmodule
